// File: rtl/ev_window_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ev_window_pkg
// Description : Shared types and helpers for the eventually-window driver.
//               Mode and state encodings plus the delay legality check,
//               which checker benches reuse to classify their own traffic.
// Revision    : 1.0 - initial release
// ============================================================================
package ev_window_pkg;

    typedef enum logic [1:0] {
        PULSE  = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2,
        RSVD   = 2'd3
    } ev_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT     = 3'd1,
        ST_PULSE    = 3'd2,
        ST_HOLD     = 3'd3,
        ST_RPT_WAIT = 3'd4
    } ev_state_e;

    // A delay is legal when it reaches the minimum and, for a bounded window
    // (max_dly != 0), does not exceed the maximum. max_dly == 0 means '$'.
    function automatic logic ev_dly_legal(input int unsigned dly,
                                          input int unsigned min_dly,
                                          input int unsigned max_dly);
        return (dly >= min_dly) && ((max_dly == 0) || (dly <= max_dly));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ev_delay_cnt.sv
`default_nettype none
// ============================================================================
// Module      : ev_delay_cnt
// Description : Loadable down-counter that saturates at zero.
//   clk      in  : clock
//   rst      in  : synchronous active-high reset (count -> 0)
//   load     in  : load load_val (has priority over en)
//   load_val in  : value to load
//   en       in  : decrement enable, holds at zero
//   zero     out : count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module ev_delay_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_one;
        end
    end

    assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/ev_window_driver.sv
`default_nettype none
// ============================================================================
// Module      : ev_window_driver
// Description : Drives signal 'a' a programmed delay after a start command,
//               as a single pulse, a held level or a periodic pulse train.
//   clk     in  : clock
//   rst     in  : synchronous active-high reset
//   start   in  : command strobe, only looked at while idle
//   mode    in  : 0 PULSE, 1 HOLD, 2 REPEAT, 3 reserved
//   dly     in  : cycles from start to first 'a'
//   clr     in  : abort the current command
//   a       out : produced signal (registered)
//   busy    out : a command is active
//   done    out : one-cycle pulse when a PULSE command completes
//   cfg_err out : one-cycle pulse when a start is rejected
// Revision    : 1.0 - initial release
// ============================================================================
module ev_window_driver
    import ev_window_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned MIN_DLY = 2,
    parameter int unsigned MAX_DLY = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] dly,
    input  logic             clr,
    output logic             a,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    ev_state_e        r_state;
    ev_mode_e         r_mode;
    logic [CNT_W-1:0] r_dly;
    logic             r_a;
    logic             r_busy;
    logic             r_done;
    logic             r_cfg_err;

    logic             w_legal;
    logic             w_accept;
    logic             w_zero;
    logic             w_load;
    logic             w_en;
    logic [CNT_W-1:0] w_load_val;

    assign w_legal  = (ev_mode_e'(mode) != RSVD) &&
                      ev_dly_legal(32'(dly), MIN_DLY, MAX_DLY);
    // clr beats start in IDLE, so a simultaneous start is simply dropped.
    assign w_accept = (r_state == ST_IDLE) && start && !clr && w_legal;

    // The counter is reloaded with dly-1 both at accept and at every REPEAT
    // pulse, which gives a first 'a' at +dly and then one every dly cycles.
    assign w_load_val = (r_state == ST_IDLE) ? (dly - c_one) : (r_dly - c_one);
    assign w_load     = w_accept ||
                        (!clr && w_zero &&
                         (((r_state == ST_WAIT) && (r_mode == REPEAT)) ||
                          (r_state == ST_RPT_WAIT)));
    assign w_en       = !clr && ((r_state == ST_WAIT) || (r_state == ST_RPT_WAIT));

    ev_delay_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .en       (w_en),
        .zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_mode    <= PULSE;
            r_dly     <= '0;
            r_a       <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            if ((r_state != ST_IDLE) && clr) begin
                // Abort: no done, even if 'a' was due this very edge.
                r_state <= ST_IDLE;
                r_a     <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_a    <= 1'b0;
                        r_busy <= 1'b0;
                        if (w_accept) begin
                            r_mode  <= ev_mode_e'(mode);
                            r_dly   <= dly;
                            r_state <= ST_WAIT;
                            r_busy  <= 1'b1;
                        end else if (start && !clr) begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (w_zero) begin
                            r_a <= 1'b1;
                            case (r_mode)
                                PULSE: begin
                                    r_state <= ST_PULSE;
                                    r_done  <= 1'b1;
                                end
                                HOLD:    r_state <= ST_HOLD;
                                default: r_state <= ST_RPT_WAIT;
                            endcase
                        end
                    end
                    ST_PULSE: begin
                        r_state <= ST_IDLE;
                        r_a     <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                    ST_HOLD: begin
                        r_a <= 1'b1;
                    end
                    ST_RPT_WAIT: begin
                        r_a <= w_zero;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_a     <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign a       = r_a;
    assign busy    = r_busy;
    assign done    = r_done;
    assign cfg_err = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_ev_window_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ev_window_driver
// Description : Scoreboard bench for ev_window_driver. Stimulus pushes the
//               expected output events; a negedge monitor pops one whenever
//               a, done or cfg_err is high and compares edge number and values.
//               A second instance runs with an unbounded window (MAX_DLY=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ev_window_driver;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       start  = 1'b0;
    logic       start0 = 1'b0;
    logic       clr    = 1'b0;
    logic [1:0] mode   = 2'd0;
    logic [7:0] dly    = 8'd0;
    logic       a, busy, done, cfg_err;
    logic       a0, busy0, done0, cfg_err0;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    int k;

    typedef struct {
        int   cyc;
        logic a;
        logic done;
        logic cfg;
    } ev_t;

    ev_t q[$];
    ev_t q0[$];

    ev_window_driver #(.CNT_W(8), .MIN_DLY(2), .MAX_DLY(5)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .dly(dly), .clr(clr),
        .a(a), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    ev_window_driver #(.CNT_W(8), .MIN_DLY(2), .MAX_DLY(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .mode(mode), .dly(dly), .clr(clr),
        .a(a0), .busy(busy0), .done(done0), .cfg_err(cfg_err0)
    );

    always #5 clk = ~clk;

    // cyc holds the number of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d after edge %0d", name, got, exp, cyc);
        end
    endtask

    task automatic cmp_ev(input string name, input ev_t e,
                          input logic ga, input logic gd, input logic gc);
        total++;
        if (e.cyc != cyc || e.a !== ga || e.done !== gd || e.cfg !== gc) begin
            bad++;
            $display("FAIL %s_event: got edge=%0d a=%b done=%b cfg_err=%b expected edge=%0d a=%b done=%b cfg_err=%b",
                     name, cyc, ga, gd, gc, e.cyc, e.a, e.done, e.cfg);
        end
    endtask

    always @(negedge clk) begin
        if (a === 1'b1 || done === 1'b1 || cfg_err === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut_unexpected: got a=%b done=%b cfg_err=%b after edge %0d, expected none",
                         a, done, cfg_err, cyc);
            end else begin
                cmp_ev("dut", q.pop_front(), a, done, cfg_err);
            end
        end
        if (a0 === 1'b1 || done0 === 1'b1 || cfg_err0 === 1'b1) begin
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut0_unexpected: got a=%b done=%b cfg_err=%b after edge %0d, expected none",
                         a0, done0, cfg_err0, cyc);
            end else begin
                cmp_ev("dut0", q0.pop_front(), a0, done0, cfg_err0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Drive a start that is sampled at edge cyc+1.
    task automatic go(input logic [1:0] m, input logic [7:0] d);
        mode  = m;
        dly   = d;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic push(input int c, input logic ea, input logic ed, input logic ec);
        ev_t e;
        e.cyc  = c;
        e.a    = ea;
        e.done = ed;
        e.cfg  = ec;
        q.push_back(e);
    endtask

    initial begin
        ev_t e0;
        step(3);
        chk("reset_a", a, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_cfg_err", cfg_err, 0);
        chk("reset_busy0", busy0, 0);
        rst = 1'b0;
        step(1);

        // PULSE, dly=3: a/done only after edge k+3, busy drops after k+4.
        k = cyc + 1;
        push(k + 3, 1'b1, 1'b1, 1'b0);
        go(2'd0, 8'd3);
        chk("pulse_busy_start", busy, 1);
        wait_until(k + 3);
        chk("pulse_busy_fire", busy, 1);
        step(1);
        chk("pulse_busy_end", busy, 0);

        // HOLD, dly=2, accepted back-to-back; a start while busy is ignored.
        k = cyc + 1;
        for (int i = 2; i <= 7; i++) push(k + i, 1'b1, 1'b0, 1'b0);
        go(2'd1, 8'd2);
        chk("hold_busy", busy, 1);
        wait_until(k + 3);
        go(2'd0, 8'd2);
        chk("start_while_busy", busy, 1);
        wait_until(k + 7);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("hold_clr_a", a, 0);
        chk("hold_clr_busy", busy, 0);

        // REPEAT, dly=4: pulses at +4, +8, +12, +16; clr at +17.
        k = cyc + 1;
        for (int i = 1; i <= 4; i++) push(k + 4 * i, 1'b1, 1'b0, 1'b0);
        go(2'd2, 8'd4);
        wait_until(k + 16);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("repeat_clr_busy", busy, 0);
        step(5);

        // Rejected starts: dly below min, above max, reserved mode.
        k = cyc + 1; push(k, 1'b0, 1'b0, 1'b1); go(2'd0, 8'd1);
        chk("dly1_busy", busy, 0);
        step(1);
        k = cyc + 1; push(k, 1'b0, 1'b0, 1'b1); go(2'd0, 8'd6);
        chk("dly6_busy", busy, 0);
        step(1);
        k = cyc + 1; push(k, 1'b0, 1'b0, 1'b1); go(2'd3, 8'd3);
        chk("mode3_busy", busy, 0);
        step(1);

        // dly at MAX_DLY is legal.
        k = cyc + 1;
        push(k + 5, 1'b1, 1'b1, 1'b0);
        go(2'd0, 8'd5);
        wait_until(k + 6);
        chk("dlymax_busy_end", busy, 0);

        // clr during WAIT: no a, no done.
        k = cyc + 1;
        go(2'd0, 8'd5);
        wait_until(k + 1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clr_wait_busy", busy, 0);
        step(6);

        // clr on the edge the pulse would fire (dly=MIN_DLY).
        k = cyc + 1;
        go(2'd0, 8'd2);
        wait_until(k + 1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clr_fire_a", a, 0);
        chk("clr_fire_busy", busy, 0);
        step(3);

        // start and clr together in IDLE: dropped.
        mode = 2'd0; dly = 8'd3; start = 1'b1; clr = 1'b1;
        step(1);
        start = 1'b0; clr = 1'b0;
        chk("start_clr_busy", busy, 0);
        step(5);

        // rst mid-HOLD.
        k = cyc + 1;
        push(k + 2, 1'b1, 1'b0, 1'b0);
        push(k + 3, 1'b1, 1'b0, 1'b0);
        go(2'd1, 8'd2);
        wait_until(k + 3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_hold_a", a, 0);
        chk("rst_hold_busy", busy, 0);

        // rst mid-WAIT.
        k = cyc + 1;
        go(2'd0, 8'd5);
        wait_until(k + 2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_wait_busy", busy, 0);
        step(6);

        // Fresh PULSE after reset.
        k = cyc + 1;
        push(k + 3, 1'b1, 1'b1, 1'b0);
        go(2'd0, 8'd3);
        chk("fresh_busy_start", busy, 1);
        wait_until(k + 4);
        chk("fresh_busy_end", busy, 0);

        // Unbounded window: dly=200 accepted, a at +200.
        k = cyc + 1;
        e0.cyc = k + 200; e0.a = 1'b1; e0.done = 1'b1; e0.cfg = 1'b0;
        q0.push_back(e0);
        mode = 2'd0; dly = 8'd200; start0 = 1'b1;
        step(1);
        start0 = 1'b0;
        chk("unbounded_busy_start", busy0, 1);
        chk("bounded_ignores", busy, 0);
        wait_until(k + 201);
        chk("unbounded_busy_end", busy0, 0);

        step(2);
        chk("dut_queue_drained", q.size(), 0);
        chk("dut0_queue_drained", q0.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by time 100000, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
